// File: rtl/mfp_eic_pkg.sv
// Shared EIC definitions: stack entry layout, default handler layout,
// and the vector/offset -> interrupt number decode.
package mfp_eic_pkg;

  typedef struct packed {
    logic [7:0] num;
    logic [7:0] level;
  } eic_entry_t;

  localparam logic [16:0] EIC_HANDLER_BASE  = 17'h100;
  localparam int          EIC_HANDLER_SHIFT = 4;

  // Offset mode: handlers sit 2**shift apart starting at base.
  function automatic logic [7:0] eic_decode(
    input logic        use_offset,
    input logic [5:0]  vec,
    input logic [17:1] off,
    input logic [16:0] base,
    input int          shift
  );
    logic [16:0] d;
    d = (off - base) >> shift;
    return use_offset ? d[7:0] : {2'b00, vec};
  endfunction

endpackage

// File: rtl/mfp_eic_ack_tracker_if.sv
// CPU-side interrupt acknowledge bundle (SI_IAck, vector, offset, IPL).
// master: core drives; slave: ack tracker / EIC observe.
interface mfp_eic_ack_tracker_if;
  logic        SI_IAck;
  logic [5:0]  SI_EICVector;
  logic [17:1] SI_Offset;
  logic [7:0]  SI_IPL;

  modport master (
    output SI_IAck, SI_EICVector,
    output SI_Offset, SI_IPL
  );

  modport slave (
    input SI_IAck, SI_EICVector,
    input SI_Offset, SI_IPL
  );
endinterface

// File: rtl/mfp_eic_ack_stack.sv
// In-service LIFO: push/pop, top entry, depth, per-IRQ occupancy.
// EIC_ACK_NESTING_EN: NEST_DEPTH-entry stack, else one register.
import mfp_eic_pkg::*;

module mfp_eic_ack_stack #(
  parameter int IRQ_COUNT  = 8,
  parameter int NEST_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  eic_entry_t           entry,
  input  logic                 pop,
  output eic_entry_t           top,
  output logic                 empty,
  output logic                 full,
  output logic [3:0]           depth,
  output logic [IRQ_COUNT-1:0] in_service
);

`ifdef EIC_ACK_NESTING_EN
  eic_entry_t mem [8];
  logic [3:0] cnt [IRQ_COUNT];
  logic [3:0] tidx;
  logic       do_push;
  logic       do_pop;

  assign tidx    = depth - 4'd1;
  assign empty   = (depth == 4'd0);
  assign full    = (depth == 4'(NEST_DEPTH));
  assign top     = empty ? '0 : mem[tidx[2:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= 4'd0;
    end else if (do_push) begin
      depth <= depth + 4'd1;
    end else if (do_pop) begin
      depth <= depth - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[depth[2:0]] <= entry;
  end

  // Count per IRQ so a number nested twice stays in service
  // until its last entry leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IRQ_COUNT; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < IRQ_COUNT; i++) begin
        if (do_push && entry.num == 8'(i))
          cnt[i] <= cnt[i] + 4'd1;
        else if (do_pop && top.num == 8'(i))
          cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    in_service = '0;
    for (int i = 0; i < IRQ_COUNT; i++)
      in_service[i] = (cnt[i] != 4'd0);
  end
`else
  eic_entry_t ent;
  logic       valid;

  // A new acknowledge simply overwrites the single entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent   <= '0;
      valid <= 1'b0;
    end else if (push) begin
      ent   <= entry;
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  assign empty = !valid;
  assign full  = valid;
  assign depth = {3'b000, valid};
  assign top   = valid ? ent : '0;

  always_comb begin
    in_service = '0;
    for (int i = 0; i < IRQ_COUNT; i++)
      in_service[i] = valid && (ent.num == 8'(i));
  end
`endif

endmodule

// File: rtl/mfp_eic_ack_tracker.sv
// Decodes CPU interrupt acks into EIC auto-clear strobes and tracks
// nested handlers; ports: SI_ClkIn/SI_Reset, bus (slave), clear/stack/error
// outputs. Nesting compiled in with EIC_ACK_NESTING_EN.
import mfp_eic_pkg::*;

module mfp_eic_ack_tracker #(
  parameter int          IRQ_COUNT     = 8,
  parameter int          NEST_DEPTH    = 4,
  parameter int          USE_OFFSET    = 0,
  parameter logic [16:0] HANDLER_BASE  = EIC_HANDLER_BASE,
  parameter int          HANDLER_SHIFT = EIC_HANDLER_SHIFT,
  parameter int          HOLDOFF       = 4
) (
  input  logic                  SI_ClkIn,
  input  logic                  SI_Reset,
  mfp_eic_ack_tracker_if.slave  bus,
  output logic                  irq_clear,
  output logic [7:0]            irq_clear_num,
  output logic [IRQ_COUNT-1:0]  in_service,
  output logic                  cur_valid,
  output logic [7:0]            cur_irq,
  output logic [3:0]            depth,
  output logic                  err_overflow,
  output logic                  err_range
);

  logic [7:0] num;
  logic       in_rng;
  logic       hit;
  logic       pop;
  logic [3:0] hold;
  eic_entry_t entry;
  eic_entry_t top;
  logic       empty;
  logic       full;

  assign num = eic_decode(USE_OFFSET != 0, bus.SI_EICVector,
                          bus.SI_Offset, HANDLER_BASE, HANDLER_SHIFT);
  assign in_rng = (num < 8'(IRQ_COUNT));
  assign hit    = bus.SI_IAck && in_rng;
  assign entry  = '{num: num, level: num + 8'd1};

  // Push wins over a same-cycle pop; holdoff then delays the pop.
  assign pop = !hit && (hold == 4'd0) && !empty
            && (bus.SI_IPL < top.level);

  mfp_eic_ack_stack #(
    .IRQ_COUNT  (IRQ_COUNT),
    .NEST_DEPTH (NEST_DEPTH)
  ) u_stack (
    .clk        (SI_ClkIn),
    .rst        (SI_Reset),
    .push       (hit),
    .entry      (entry),
    .pop        (pop),
    .top        (top),
    .empty      (empty),
    .full       (full),
    .depth      (depth),
    .in_service (in_service)
  );

  assign cur_valid = !empty;
  assign cur_irq   = top.num;

  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      irq_clear     <= 1'b0;
      irq_clear_num <= 8'd0;
      hold          <= 4'd0;
      err_range     <= 1'b0;
    end else begin
      irq_clear <= hit;
      if (hit) irq_clear_num <= num;
      if (hit)
        hold <= 4'(HOLDOFF);
      else if (hold != 4'd0)
        hold <= hold - 4'd1;
      if (bus.SI_IAck && !in_rng) err_range <= 1'b1;
    end
  end

`ifdef EIC_ACK_NESTING_EN
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset)
      err_overflow <= 1'b0;
    else if (hit && full)
      err_overflow <= 1'b1;
  end
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mfp_eic_ack_tracker.sv
// Self-checking bench: vector-mode and offset-mode trackers on one bus,
// checked each cycle against a stack model plus directed literal cases.
module tb_mfp_eic_ack_tracker;

  localparam int IRQN = 8;
  localparam int ND   = 2;
  localparam int HO   = 4;
`ifdef EIC_ACK_NESTING_EN
  localparam int NEST = 1;
  localparam int CAP  = ND;
`else
  localparam int NEST = 0;
  localparam int CAP  = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mfp_eic_ack_tracker_if bus();

  logic            clr  [2];
  logic [7:0]      clrn [2];
  logic [IRQN-1:0] isv  [2];
  logic            cv   [2];
  logic [7:0]      ci   [2];
  logic [3:0]      dp   [2];
  logic            eov  [2];
  logic            erg  [2];

  mfp_eic_ack_tracker #(
    .IRQ_COUNT(IRQN), .NEST_DEPTH(ND), .USE_OFFSET(0),
    .HANDLER_BASE(17'h100), .HANDLER_SHIFT(4), .HOLDOFF(HO)
  ) dut_vec (
    .SI_ClkIn(clk), .SI_Reset(rst), .bus(bus.slave),
    .irq_clear(clr[0]), .irq_clear_num(clrn[0]),
    .in_service(isv[0]), .cur_valid(cv[0]), .cur_irq(ci[0]),
    .depth(dp[0]), .err_overflow(eov[0]), .err_range(erg[0])
  );

  mfp_eic_ack_tracker #(
    .IRQ_COUNT(IRQN), .NEST_DEPTH(ND), .USE_OFFSET(1),
    .HANDLER_BASE(17'h100), .HANDLER_SHIFT(4), .HOLDOFF(HO)
  ) dut_off (
    .SI_ClkIn(clk), .SI_Reset(rst), .bus(bus.slave),
    .irq_clear(clr[1]), .irq_clear_num(clrn[1]),
    .in_service(isv[1]), .cur_valid(cv[1]), .cur_irq(ci[1]),
    .depth(dp[1]), .err_overflow(eov[1]), .err_range(erg[1])
  );

  // Reference model: stack of (num, level) per instance.
  int sn [2][8];
  int sl [2][8];
  int sz [2];
  int hold [2];
  int m_clr [2];
  int m_clrn [2];
  int m_ovf [2];
  int m_rng [2];

  int tests = 0;
  int fails = 0;

  function automatic int dec(int m, int v, int o);
    if (m == 0) return v;
    return (((o - 'h100) & 'h1FFFF) >> 4) & 'hFF;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      sz[m] = 0; hold[m] = 0; m_clr[m] = 0;
      m_clrn[m] = 0; m_ovf[m] = 0; m_rng[m] = 0;
    end
  endtask

  task automatic model_step(int ia, int v, int o, int ipl);
    for (int m = 0; m < 2; m++) begin
      int num;
      int hit;
      num = dec(m, v, o);
      hit = (ia != 0 && num < IRQN) ? 1 : 0;
      m_clr[m] = hit;
      if (hit != 0) begin
        m_clrn[m] = num;
        if (NEST != 0) begin
          if (sz[m] < CAP) begin
            sn[m][sz[m]] = num; sl[m][sz[m]] = num + 1;
            sz[m]++;
          end else begin
            m_ovf[m] = 1;
          end
        end else begin
          sn[m][0] = num; sl[m][0] = num + 1; sz[m] = 1;
        end
      end else if (ia != 0) begin
        m_rng[m] = 1;
      end
      if (hit == 0 && hold[m] == 0 && sz[m] > 0
          && ipl < sl[m][sz[m]-1])
        sz[m]--;
      if (hit != 0) hold[m] = HO;
      else if (hold[m] > 0) hold[m]--;
    end
  endtask

  function automatic int exp_isv(int m);
    int r;
    r = 0;
    for (int i = 0; i < sz[m]; i++) r |= (1 << sn[m][i]);
    return r;
  endfunction

  task automatic chk(string name, int m, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, m, act, exp);
    end
  endtask

  task automatic compare();
    for (int m = 0; m < 2; m++) begin
      chk("irq_clear", m, int'(clr[m]), m_clr[m]);
      chk("irq_clear_num", m, int'(clrn[m]), m_clrn[m]);
      chk("in_service", m, int'(isv[m]), exp_isv(m));
      chk("cur_valid", m, int'(cv[m]), (sz[m] > 0) ? 1 : 0);
      chk("cur_irq", m, int'(ci[m]),
          (sz[m] > 0) ? sn[m][sz[m]-1] : 0);
      chk("depth", m, int'(dp[m]), sz[m]);
      chk("err_overflow", m, int'(eov[m]), m_ovf[m]);
      chk("err_range", m, int'(erg[m]), m_rng[m]);
    end
  endtask

  task automatic cyc(int ia, int v, int o, int ipl);
    bus.SI_IAck      = (ia != 0);
    bus.SI_EICVector = 6'(v);
    bus.SI_Offset    = 17'(o);
    bus.SI_IPL       = 8'(ipl);
    model_step(ia, v, o, ipl);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic reset_literals(string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_clear"}, m, int'(clr[m]), 0);
      chk({tag, "_clrnum"}, m, int'(clrn[m]), 0);
      chk({tag, "_isv"}, m, int'(isv[m]), 0);
      chk({tag, "_valid"}, m, int'(cv[m]), 0);
      chk({tag, "_depth"}, m, int'(dp[m]), 0);
      chk({tag, "_errs"}, m, int'({eov[m], erg[m]}), 0);
    end
  endtask

  // Called at a negedge: reset takes effect without a clock edge.
  task automatic async_reset();
    bus.SI_IAck = 1'b0;
    rst = 1'b1;
    #1;
    reset_literals("async_rst");
    model_reset();
    @(negedge clk);
    compare();
    rst = 1'b0;
  endtask

  initial begin
    int ipl;
    bus.SI_IAck = 1'b0;
    bus.SI_EICVector = '0;
    bus.SI_Offset = '0;
    bus.SI_IPL = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_literals("rst");
    compare();
    rst = 1'b0;

    // Vector 3 acked, IPL raised to 4, then dropped to 0.
    cyc(1, 3, 0, 4);
    chk("v3_clear", 0, int'(clr[0]), 1);
    chk("v3_num", 0, int'(clrn[0]), 3);
    chk("v3_isv", 0, int'(isv[0]), 8'h08);
    chk("v3_depth", 0, int'(dp[0]), 1);
    repeat (6) cyc(0, 0, 0, 4);
    chk("v3_hold", 0, int'(dp[0]), 1);
    cyc(0, 0, 0, 0);
    chk("v3_pop_isv", 0, int'(isv[0]), 0);
    chk("v3_pop_valid", 0, int'(cv[0]), 0);
    async_reset();

    // Offset 0x150 decodes to IRQ 5.
    cyc(1, 0, 'h150, 0);
    chk("off_clear", 1, int'(clr[1]), 1);
    chk("off_num", 1, int'(clrn[1]), 5);
    async_reset();

    // Nesting: IRQ1 then IRQ6; IPL 2 pops only 6.
    cyc(1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 2);
    cyc(1, 6, 0, 2);
    repeat (5) cyc(0, 0, 0, 7);
    cyc(0, 0, 0, 2);
    cyc(0, 0, 0, 2);
    chk("nest_depth", 0, int'(dp[0]), NEST);
    chk("nest_cur", 0, int'(ci[0]), NEST);
    cyc(0, 0, 0, 0);
    chk("nest_empty", 0, int'(dp[0]), 0);
    async_reset();

    // Overflow with two stack entries.
    cyc(1, 1, 0, 0);
    chk("ovf_c1", 0, int'(clr[0]), 1);
    cyc(1, 2, 0, 0);
    chk("ovf_c2", 0, int'(clr[0]), 1);
    cyc(1, 3, 0, 0);
    chk("ovf_c3", 0, int'(clr[0]), 1);
    chk("ovf_depth", 0, int'(dp[0]), CAP);
    chk("ovf_flag", 0, int'(eov[0]), NEST);
    async_reset();

    // Out-of-range vector, then holdoff timing.
    cyc(1, 40, 0, 0);
    chk("rng_clear", 0, int'(clr[0]), 0);
    chk("rng_flag", 0, int'(erg[0]), 1);
    cyc(1, 2, 0, 0);
    for (int i = 0; i < HO; i++) begin
      cyc(0, 0, 0, 0);
      chk("holdoff_keep", 0, int'(dp[0]), 1);
    end
    cyc(0, 0, 0, 0);
    chk("holdoff_pop", 0, int'(dp[0]), 0);
    chk("rng_sticky", 0, int'(erg[0]), 1);

    // Reset with entries on the stack.
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    chk("pre_rst_depth", 0, int'(dp[0]), CAP);
    async_reset();

    // Randomized traffic.
    ipl = 0;
    for (int n = 0; n < 3000; n++) begin
      int ia;
      int v;
      int o;
      ia = ($urandom % 4 == 0) ? 1 : 0;
      v = ($urandom % 8 == 0) ? int'($urandom % 64)
                              : int'($urandom % 10);
      if ($urandom % 10 == 0)
        o = int'($urandom % 'h20000);
      else
        o = 'h100 + int'($urandom % 11) * 16
            + int'($urandom % 16);
      if ($urandom % 6 == 0) ipl = int'($urandom % 10);
      cyc(ia, v, o, ipl);
      if ($urandom % 600 == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
